seq_cmp_ctrl: RTL and testbench
===============================

SEQ_CMP_CTRL -- requirements
Module: seq_cmp_ctrl

Interface
REQ-001 Parameter NSLICE, default 4, is the number of 3-bit slices per operand; legal range is 2..16.
REQ-002 Parameter W, default 3*NSLICE, is the operand width; it SHALL always equal 3*NSLICE.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit: request to compare a against b; honoured only while ready=1.
REQ-006 Port a, input, W bits: unsigned operand A, sampled on the accepting edge only.
REQ-007 Port b, input, W bits: unsigned operand B, sampled on the accepting edge only.
REQ-008 Port ready, output, 1 bit: high exactly while in IDLE.
REQ-009 Port done, output, 1 bit: one-cycle pulse marking a new valid result.
REQ-010 Port lt, output, 1 bit: final result A<B, held until the next done.
REQ-011 Port eq, output, 1 bit: final result A==B, held until the next done.
REQ-012 Port gt, output, 1 bit: final result A>B, held until the next done.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE, start=1 at an edge SHALL latch a and b, set slice index idx=0, load cascade {l,e,g}={0,1,0}, and move to RUN.
REQ-015 Each RUN edge SHALL compare slice idx (bits 3*idx+2 : 3*idx, LSB slice first) with the cascade and register the slice result into the cascade; idx then increments.
REQ-016 The slice rules SHALL be: lt = (As<Bs) or (As==Bs and l); eq = (As==Bs and e); gt = (As>Bs) or (As==Bs and g).
REQ-017 On the RUN edge where idx==NSLICE-1, the FSM SHALL load lt/eq/gt from that slice result and move to DONE.
REQ-018 done SHALL be high only in DONE; DONE SHALL return to IDLE on the next edge unconditionally.
REQ-019 Latency: with start accepted at edge T, done SHALL be high between edges T+NSLICE and T+NSLICE+1, and ready SHALL return high after edge T+NSLICE+1.
REQ-020 start in RUN or DONE SHALL be ignored: no re-latch, no restart, no queuing.
REQ-021 Changes on a or b after the accepting edge SHALL NOT affect the result in progress.
REQ-022 The cascade register and {lt,eq,gt} SHALL remain one-hot at all times after reset.
REQ-023 The idx counter SHALL be ceil(log2(NSLICE)) bits wide and SHALL never exceed NSLICE-1.
REQ-024 Back-to-back operation: start held high continuously SHALL yield one compare every NSLICE+2 cycles.

Reset
REQ-025 Asserting rst_n low SHALL immediately force state=IDLE, idx=0, cascade={0,1,0}, lt=0, eq=1, gt=0, done=0 and ready=1.
REQ-026 Reset asserted during RUN or DONE SHALL abort the operation, and no done pulse SHALL follow.
REQ-027 The first start after rst_n deasserts SHALL be accepted normally.

Structure
REQ-028 Package seq_cmp_pkg SHALL hold the state encodings (IDLE, RUN, DONE) and the cascade reset constant CASC_INIT=3'b010 in {l,e,g} order.
REQ-029 The slice comparison SHALL be a separate sub-module, cmp3_slice, with ports As[2:0], Bs[2:0], l, e and g, and outputs lt, eq and gt; it is instantiated once and time-multiplexed by idx.

Verification (NSLICE=4, W=12)
REQ-030 Equal operands: a=12'h123, b=12'h123, start -> done at T+4 with lt=0, eq=1, gt=0.
REQ-031 MSB decides: a=12'h800, b=12'h7FF -> gt=1 even though every lower slice reported lt.
REQ-032 LSB-only difference: a=12'hFFE, b=12'hFFF -> lt=1, proving the cascade propagates through equal upper slices.
REQ-033 Busy rejection: a=12'h001, b=12'h002, then start pulsed in RUN with a=12'hFFF -> single done with lt=1, and ready=0 throughout RUN.
REQ-034 Reset mid-operation: rst_n low at T+2 -> no done pulse; outputs 0/1/0 with ready=1; the next compare a=12'h010, b=12'h00F -> gt=1.
REQ-035 Continuous start with alternating operand pairs -> done pulses every 6 cycles, each with the correct result, and lt/eq/gt stable between pulses.

Source files
------------

// File: rtl/seq_cmp_pkg.sv
// seq_cmp_pkg: shared types and constants for the sequential comparator.
//   state_t   : controller states IDLE / RUN / DONE
//   CASC_INIT : cascade seed in {l,e,g} order (operands "equal so far")
package seq_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] CASC_INIT = 3'b010;

endpackage

// File: rtl/seq_cmp_ctrl_slice.sv
// cmp3_slice: combinational 3-bit magnitude compare with cascade input.
// Ports:
//   As, Bs    : 3-bit operand slices
//   l, e, g   : cascade from the less significant slices
//   lt, eq, gt: combined result including this slice
// A difference in this slice overrides the cascade; an equal slice passes it on.
module cmp3_slice (
    input  logic [2:0] As,
    input  logic [2:0] Bs,
    input  logic       l,
    input  logic       e,
    input  logic       g,
    output logic       lt,
    output logic       eq,
    output logic       gt
);

    logic same;

    assign same = (As == Bs);
    assign lt   = (As < Bs) | (same & l);
    assign eq   = same & e;
    assign gt   = (As > Bs) | (same & g);

endmodule

// File: rtl/seq_cmp_ctrl.sv
// seq_cmp_ctrl: multi-cycle unsigned comparator, one 3-bit slice per cycle,
// LSB slice first, through a single time-multiplexed cmp3_slice.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : compare request, honoured only while ready
//   a, b           : W-bit operands, latched on the accepting edge
//   ready          : high while idle
//   done           : one-cycle pulse when a new result is loaded
//   lt, eq, gt     : one-hot result, held until the next done
module seq_cmp_ctrl
    import seq_cmp_pkg::*;
#(
    parameter int NSLICE = 4,
    parameter int W      = 3 * NSLICE
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ready,
    output logic         done,
    output logic         lt,
    output logic         eq,
    output logic         gt
);

    localparam int unsigned IDXW = $clog2(NSLICE);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSLICE - 1);

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [2:0]      casc_q, casc_d;
    logic [2:0]      res_q, res_d;

    logic [2:0]      sl_a, sl_b;
    logic            sl_lt, sl_eq, sl_gt;

    // Slice select: idx never exceeds NSLICE-1, so exactly one arm matches.
    always_comb begin
        sl_a = '0;
        sl_b = '0;
        for (int unsigned i = 0; i < NSLICE; i++) begin
            if (idx_q == IDXW'(i)) begin
                sl_a = a_q[3*i +: 3];
                sl_b = b_q[3*i +: 3];
            end
        end
    end

    cmp3_slice u_slice (
        .As (sl_a),
        .Bs (sl_b),
        .l  (casc_q[2]),
        .e  (casc_q[1]),
        .g  (casc_q[0]),
        .lt (sl_lt),
        .eq (sl_eq),
        .gt (sl_gt)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (idx_q == IDX_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready = (state_q == IDLE);
        done  = (state_q == DONE);
    end

    // Datapath next-state
    always_comb begin
        idx_d  = idx_q;
        a_d    = a_q;
        b_d    = b_q;
        casc_d = casc_q;
        res_d  = res_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d    = a;
                    b_d    = b;
                    idx_d  = '0;
                    casc_d = CASC_INIT;
                end
            end
            RUN: begin
                casc_d = {sl_lt, sl_eq, sl_gt};
                if (idx_q == IDX_LAST) begin
                    res_d = {sl_lt, sl_eq, sl_gt};
                    idx_d = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            casc_q <= CASC_INIT;
            res_q  <= CASC_INIT;
        end else begin
            idx_q  <= idx_d;
            a_q    <= a_d;
            b_q    <= b_d;
            casc_q <= casc_d;
            res_q  <= res_d;
        end
    end

    assign lt = res_q[2];
    assign eq = res_q[1];
    assign gt = res_q[0];

endmodule

// File: tb/tb_seq_cmp_ctrl.sv
// tb_seq_cmp_ctrl: self-checking bench for seq_cmp_ctrl (NSLICE=4, W=12).
// A cycle-count model predicts ready/done/result from plain arithmetic
// compares; directed cases pin the model with literal expectations.
module tb_seq_cmp_ctrl;

    localparam int NSLICE = 4;
    localparam int W      = 12;

    localparam logic [2:0] R_LT = 3'b100;
    localparam logic [2:0] R_EQ = 3'b010;
    localparam logic [2:0] R_GT = 3'b001;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         ready, done, lt, eq, gt;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    seq_cmp_ctrl #(.NSLICE(NSLICE), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .done  (done),
        .lt    (lt),
        .eq    (eq),
        .gt    (gt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic       m_ready = 1'b1;
    logic       m_done  = 1'b0;
    logic [2:0] m_res   = R_EQ;
    logic [2:0] m_pend  = R_EQ;
    int         m_k     = 0;

    function automatic logic [2:0] ref_cmp(input logic [W-1:0] x, input logic [W-1:0] y);
        return {x < y, x == y, x > y};
    endfunction

    // Accept at edge T; done rises at T+NSLICE, ready returns at T+NSLICE+1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready <= 1'b1;
            m_done  <= 1'b0;
            m_res   <= R_EQ;
            m_k     <= 0;
        end else if (m_ready) begin
            if (start) begin
                m_ready <= 1'b0;
                m_pend  <= ref_cmp(a, b);
                m_k     <= 0;
            end
        end else begin
            m_k <= m_k + 1;
            if (m_k + 1 == NSLICE) begin
                m_done <= 1'b1;
                m_res  <= m_pend;
            end
            if (m_k + 1 == NSLICE + 1) begin
                m_done  <= 1'b0;
                m_ready <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", 32'(ready), 32'(m_ready));
            check("done", 32'(done), 32'(m_done));
            check("result", 32'({lt, eq, gt}), 32'(m_res));
            check("onehot", 32'($onehot({lt, eq, gt})), 32'd1);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_ready();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready) return;
        end
        fail_now("wait_ready");
    endtask

    task automatic do_cmp(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [2:0] exp, input bit busy, input string name);
        int         dcount;
        int         dcyc;
        logic [2:0] got;
        dcount = 0;
        dcyc   = 0;
        got    = '0;
        wait_ready();
        #1;
        a     = av;
        b     = bv;
        start = 1'b1;
        for (int c = 1; c <= NSLICE + 3; c++) begin
            @(negedge clk);
            if (done) begin
                dcount++;
                dcyc = c;
                got  = {lt, eq, gt};
            end
            if (c <= NSLICE + 1) check({name, "_busy"}, 32'(ready), 32'd0);
            #1;
            if (c == 1) begin
                // operands move after acceptance; optional start pulse in RUN
                start = busy;
                a     = busy ? 12'hFFF : ~av;
                b     = ~bv;
            end else begin
                start = 1'b0;
            end
        end
        check({name, "_ndone"}, 32'(dcount), 32'd1);
        check({name, "_lat"}, 32'(dcyc), 32'(NSLICE + 1));
        check({name, "_res"}, 32'(got), 32'(exp));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int         dcount;
        int         last;
        int         pulses;
        bit         pair;

        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res", 32'({lt, eq, gt}), 32'(R_EQ));
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        do_cmp(12'h123, 12'h123, R_EQ, 1'b0, "equal");
        do_cmp(12'h800, 12'h7FF, R_GT, 1'b0, "msb");
        do_cmp(12'hFFE, 12'hFFF, R_LT, 1'b0, "lsb");
        do_cmp(12'h001, 12'h002, R_LT, 1'b1, "busyrej");

        // Reset in the middle of RUN
        wait_ready();
        #1;
        a     = 12'h123;
        b     = 12'h456;
        start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check("abort_res", 32'({lt, eq, gt}), 32'(R_EQ));
        #1 rst_n = 1'b1;
        dcount = 0;
        repeat (NSLICE + 4) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("abort_nodone", 32'(dcount), 32'd0);
        do_cmp(12'h010, 12'h00F, R_GT, 1'b0, "after_rst");

        // Continuous start with alternating operand pairs
        wait_ready();
        #1;
        pair   = 1'b0;
        a      = 12'h5A5;
        b      = 12'h5A6;
        start  = 1'b1;
        last   = -1;
        pulses = 0;
        for (int cyc = 1; cyc <= 60 && pulses < 5; cyc++) begin
            @(negedge clk);
            if (done) begin
                check("b2b_res", 32'({lt, eq, gt}), pair ? 32'(R_GT) : 32'(R_LT));
                if (last >= 0) check("b2b_period", 32'(cyc - last), 32'(NSLICE + 2));
                last = cyc;
                pulses++;
                #1;
                pair = ~pair;
                a    = pair ? 12'hABC : 12'h5A5;
                b    = pair ? 12'h123 : 12'h5A6;
            end
        end
        check("b2b_pulses", 32'(pulses), 32'd5);
        #1 start = 1'b0;

        // Randomized traffic, checked by the per-cycle model compare
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            #1;
            start = ($urandom_range(0, 3) != 0);
            a     = W'($urandom);
            case ($urandom_range(0, 2))
                0: b = W'($urandom);
                1: b = a;
                default: b = a ^ (W'(1) << $urandom_range(0, W - 1));
            endcase
            rst_n = ($urandom_range(0, 99) != 0);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b0;
        repeat (NSLICE + 3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
